alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side sequencer for the 16-bit ALU datapath. It accepts one operation at a time over a valid/ready command port and drives the opcode and operand inputs of the ALU breadboard. It waits out the ALU/accumulator settle latency, then returns the registered result over a valid/ready response port. This replaces hand-timed stimulus with a handshaked responder, so the ALU can be driven by any upstream initiator.

## Interface

Parameters:
- SETTLE_CYCLES, default 2: clock edges between loading operands and sampling `alu_result`. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge. One clock domain only.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  upstream presents a command.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_opcode  input  4  ALU opcode, same encoding as the ALU control logic.
- cmd_a  input  16  operand A.
- cmd_b  input  16  operand B.
- alu_opcode  output  4  registered opcode to the ALU.
- alu_a  output  16  registered operand A to the ALU.
- alu_b  output  16  registered operand B to the ALU.
- alu_result  input  16  ALU accumulator output (finalOutput).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  downstream accepts the response.
- rsp_data  output  16  captured result; 0 on error.
- rsp_opcode  output  4  opcode of the command being answered.
- rsp_error  output  1  command carried an illegal opcode.
- busy  output  1  high in WAIT or RESP.
- op_count  output  16  completed responses, including errored ones; wraps.

## Operation

- Legal opcodes: 0000 AND, 0001 OR, 0010 NOT, 0011 XOR, 0100 NAND, 0101 NOR, 0110 XNOR, 1000 ADD, 1001 SUB, 1010 SHR, 1011 SHL, 1111 CLEAR.
- Illegal opcodes: 0111, 1100, 1101, 1110.
- FSM states:
  - IDLE: `cmd_ready` = 1.
  - WAIT: settle counter `cnt` (4 bits) runs.
  - RESP: `rsp_valid` = 1.
- IDLE, when `cmd_valid && cmd_ready`:
  - Legal opcode: load `alu_opcode`/`alu_a`/`alu_b` from cmd_*. Latch `rsp_opcode`. Set `cnt` = 0. Go to WAIT.
  - Illegal opcode: `alu_*` unchanged. Set `rsp_opcode` = cmd_opcode, `rsp_error` = 1, `rsp_data` = 0. Go directly to RESP.
- WAIT:
  - If `cnt == SETTLE_CYCLES-1`: `rsp_data <= alu_result`, `rsp_error <= 0`, go to RESP.
  - Otherwise `cnt <= cnt+1`.
  - `alu_*` held stable throughout.
- RESP:
  - `rsp_*` held stable while `rsp_ready` = 0.
  - On `rsp_valid && rsp_ready`: go to IDLE, `op_count <= op_count+1` (0xFFFF wraps to 0x0000).
- `alu_*` keep their last values in IDLE. They are not cleared after a response.
- Outputs are derived from state:
  - `cmd_ready` = (state == IDLE) && rst_n.
  - `busy` = (state != IDLE).
  - `rsp_valid` = (state == RESP).
- The command port ignores `cmd_valid` outside IDLE. Upstream must hold its command until accepted.
- CLEAR (1111) is an ordinary legal command; the response carries whatever the ALU returns (0 expected).
- No arithmetic is done in this block. Carry and overflow are not observed.

## Timing

- Reset (rst_n = 0 at a rising edge) forces:
  - state = IDLE;
  - `alu_opcode` = 4'b1111, `alu_a` = 0, `alu_b` = 0;
  - `rsp_data` = 0, `rsp_opcode` = 0, `rsp_error` = 0;
  - `op_count` = 0, `cnt` = 0.
- While rst_n = 0: `cmd_ready` = 0, `rsp_valid` = 0, `busy` = 0.
- Reset in WAIT or RESP abandons the operation. No response is issued and `op_count` is not incremented.
- Legal command accepted at edge E0:
  - `alu_*` valid after E0;
  - `alu_result` sampled at edge E0+SETTLE_CYCLES;
  - `rsp_valid` high after that same edge.
- Illegal command accepted at E0: `rsp_valid` high after E0 (1-cycle latency).
- Response handshaked at edge E1: `cmd_ready` high after E1. The next command can be accepted at E1+1 at the earliest. Throughput is at most one command per SETTLE_CYCLES+2 cycles.
- `rsp_ready` held high in advance: response completes on the first RESP edge.
- `cmd_valid` asserted during RESP together with `rsp_ready`: the response completes first; the command is accepted on the following edge.

## Test plan

- Bench ALU model: registers f(alu_opcode, alu_a, alu_b) into `alu_result` with 2-cycle latency (SETTLE_CYCLES = 2).
- AND, a = 0xC001, b = 0x8001, `rsp_ready` = 1 -> `rsp_valid` 2 edges after accept, `rsp_data` = 0x8001, `rsp_error` = 0, `op_count` = 1.
- SUB, a = 0x0002, b = 0x0003 -> `rsp_data` = 0xFFFF. ADD with the same operands -> 0x0005. SHL a = 0x0002 -> 0x0004.
- OR 0x0002|0x0001 with `rsp_ready` low for 5 cycles -> `rsp_valid`/`rsp_data` = 0x0003 stable, `cmd_ready` = 0, `busy` = 1; completes on the edge where `rsp_ready` rises.
- Opcode 0111 while `alu_opcode` = 0000 -> `rsp_valid` after 1 edge, `rsp_error` = 1, `rsp_data` = 0, `alu_opcode` stays 0000, `op_count` increments.
- Reset asserted during WAIT -> next cycle `alu_opcode` = 1111, `alu_a`/`alu_b` = 0, no `rsp_valid`, `op_count` = 0; new command accepted 1 edge after reset release.
- Preload 65535 completed ops (or force `op_count`), run one more -> `op_count` wraps to 0x0000.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - valid/ready command sequencer for the 16-bit ALU datapath
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_opcode,
  output logic        rsp_error,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_opcode_q, alu_opcode_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [3:0]  rsp_opcode_q, rsp_opcode_d;
  logic        rsp_error_q, rsp_error_d;
  logic [15:0] op_count_q, op_count_d;
  logic        cmd_legal;

  // Holes in the ALU control encoding: 0111 and 1100..1110
  assign cmd_legal = !((cmd_opcode == 4'b0111) || (cmd_opcode == 4'b1100) ||
                       (cmd_opcode == 4'b1101) || (cmd_opcode == 4'b1110));

  assign cmd_ready  = (state_q == ST_IDLE) && rst_n;
  assign busy       = (state_q != ST_IDLE) && rst_n;
  assign rsp_valid  = (state_q == ST_RESP) && rst_n;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_error  = rsp_error_q;
  assign op_count   = op_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_error_d  = rsp_error_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rsp_opcode_d = cmd_opcode;
          if (cmd_legal) begin
            alu_opcode_d = cmd_opcode;
            alu_a_d      = cmd_a;
            alu_b_d      = cmd_b;
            cnt_d        = 4'd0;
            state_d      = ST_WAIT;
          end else begin
            rsp_error_d = 1'b1;
            rsp_data_d  = 16'h0000;
            state_d     = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_data_d  = alu_result;
          rsp_error_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      alu_opcode_q <= 4'b1111;
      alu_a_q      <= 16'h0000;
      alu_b_q      <= 16'h0000;
      rsp_data_q   <= 16'h0000;
      rsp_opcode_q <= 4'd0;
      rsp_error_q  <= 1'b0;
      op_count_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_error_q  <= rsp_error_d;
      op_count_q   <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a registered ALU model
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_opcode;
  logic        rsp_error;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_opcode (rsp_opcode),
    .rsp_error  (rsp_error),
    .busy       (busy),
    .op_count   (op_count)
  );

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return ~a;
      4'b0011: return a ^ b;
      4'b0100: return ~(a & b);
      4'b0101: return ~(a | b);
      4'b0110: return ~(a ^ b);
      4'b1000: return a + b;
      4'b1001: return a - b;
      4'b1010: return a >> 1;
      4'b1011: return a << 1;
      default: return 16'h0000;
    endcase
  endfunction

  // One register stage: value is ready to be sampled two edges after the operands load
  always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    logic [15:0] cnt0;
    cnt0 = op_count;
    rsp_ready = 1'b1;
    issue(tag, op, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_data});
    check({tag, "_err"}, {31'd0, rsp_error}, {31'd0, exp_err});
    check({tag, "_op"}, {28'd0, rsp_opcode}, {28'd0, op});
    tick();
    check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_cnt"}, {16'd0, op_count}, {16'd0, 16'(cnt0 + 16'd1)});
  endtask

  initial begin
    int lat;
    logic [15:0] cnt0;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_opcode = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
    tick(); tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_op", {28'd0, alu_opcode}, 32'hF);
    check("rst_alu_a", {16'd0, alu_a}, 32'd0);
    check("rst_alu_b", {16'd0, alu_b}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_error}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);

    run_op("and", 4'b0000, 16'hC001, 16'h8001, 16'h8001, 1'b0, 2);
    check("and_count", {16'd0, op_count}, 32'd1);

    run_op("ill7", 4'b0111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 0);
    check("ill7_alu_op", {28'd0, alu_opcode}, 32'h0);
    check("ill7_alu_a", {16'd0, alu_a}, 32'hC001);

    run_op("sub", 4'b1001, 16'h0002, 16'h0003, 16'hFFFF, 1'b0, 2);
    run_op("add", 4'b1000, 16'h0002, 16'h0003, 16'h0005, 1'b0, 2);
    run_op("shl", 4'b1011, 16'h0002, 16'h0000, 16'h0004, 1'b0, 2);
    run_op("not", 4'b0010, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 2);
    run_op("ill14", 4'b1110, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 0);
    run_op("clear", 4'b1111, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 2);

    // Backpressure, with a follow-on command presented alongside rsp_ready
    cnt0 = op_count;
    rsp_ready = 1'b0;
    issue("or", 4'b0001, 16'h0002, 16'h0001);
    wait_rsp(lat);
    check("or_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_data", {16'd0, rsp_data}, 32'h0003);
      check("hold_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    cmd_valid = 1'b1; cmd_opcode = 4'b1000; cmd_a = 16'h0010; cmd_b = 16'h0020;
    rsp_ready = 1'b1;
    tick();
    check("hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("hs_busy", {31'd0, busy}, 32'd0);
    check("hs_count", {16'd0, op_count}, {16'd0, 16'(cnt0 + 16'd1)});
    tick();
    cmd_valid = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_alu_op", {28'd0, alu_opcode}, 32'h8);
    check("b2b_alu_a", {16'd0, alu_a}, 32'h0010);
    wait_rsp(lat);
    check("b2b_lat", lat, 2);
    check("b2b_data", {16'd0, rsp_data}, 32'h0030);
    tick();

    // Reset while waiting on the ALU
    issue("xor", 4'b0011, 16'hFFFF, 16'h0F0F);
    rst_n = 1'b0;
    tick();
    check("wrst_alu_op", {28'd0, alu_opcode}, 32'hF);
    check("wrst_alu_a", {16'd0, alu_a}, 32'd0);
    check("wrst_alu_b", {16'd0, alu_b}, 32'd0);
    check("wrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("wrst_count", {16'd0, op_count}, 32'd0);
    check("wrst_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 4'b0110; cmd_a = 16'h00FF; cmd_b = 16'h0F0F;
    tick();
    cmd_valid = 1'b0;
    check("post_busy", {31'd0, busy}, 32'd1);
    check("post_alu_op", {28'd0, alu_opcode}, 32'h6);
    wait_rsp(lat);
    check("post_lat", lat, 2);
    check("post_data", {16'd0, rsp_data}, 32'hF00F);
    tick();
    check("post_count", {16'd0, op_count}, 32'd1);

    // Counter wrap from 0xFFFF
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    check("pre_wrap", {16'd0, op_count}, 32'hFFFF);
    run_op("nand", 4'b0100, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 2);
    check("wrap", {16'd0, op_count}, 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
